// File: rtl/secded_pkg.sv
// Shared SECDED helpers: check-width function, codeword layout helpers and width constants.
package secded_pkg;

    // Hamming check bits r (smallest with 2^r >= dw + r + 1) plus one overall-parity bit
    function automatic int unsigned ecc_width(input int unsigned dw);
        int unsigned r;
        r = 0;
        for (int unsigned i = 1; i < 31; i++) begin
            if (r == 0 && (32'd1 << i) >= dw + i + 1) r = i;
        end
        return r + 1;
    endfunction

    function automatic logic is_pow2(input int unsigned p);
        return (p != 0) && ((p & (p - 1)) == 0);
    endfunction

    // Codeword position of data bit k: every power-of-two position below it is skipped
    function automatic int unsigned data_pos(input int unsigned k);
        int unsigned p;
        p = k + 1;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) <= p) p = p + 1;
        end
        return p;
    endfunction

    function automatic int unsigned cw_width(input int unsigned dw, input int unsigned ew);
        return dw + ew;
    endfunction

    function automatic int unsigned syn_width(input int unsigned ew);
        return ew - 1;
    endfunction

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ECC_WIDTH  = ecc_width(DEF_DATA_WIDTH);
    localparam int unsigned DEF_CW_WIDTH   = cw_width(DEF_DATA_WIDTH, DEF_ECC_WIDTH);
    localparam int unsigned DEF_SYN_WIDTH  = syn_width(DEF_ECC_WIDTH);

endpackage

// File: rtl/secded_stream_channel_decoder.sv
// Combinational SECDED decoder: syndrome/parity classification and single-bit correction.
module secded_decoder
    import secded_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ECC_WIDTH  = 5
) (
    input  logic [DATA_WIDTH+ECC_WIDTH-1:0] codeword,
    output logic [DATA_WIDTH-1:0]           data_c,
    output logic                            single_err_c,
    output logic                            double_err_c
);

    localparam int unsigned CW_WIDTH  = cw_width(DATA_WIDTH, ECC_WIDTH);
    localparam int unsigned SYN_WIDTH = syn_width(ECC_WIDTH);
    localparam int unsigned IDX_W     = $clog2(CW_WIDTH);
    localparam int unsigned DIDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [SYN_WIDTH-1:0] syndrome;
    logic                 parity_bad;
    logic [CW_WIDTH-1:0]  flip;
    logic [CW_WIDTH-1:0]  fixed;

    always_comb begin
        syndrome     = '0;
        flip         = '0;
        fixed        = codeword;
        data_c       = '0;
        single_err_c = 1'b0;
        double_err_c = 1'b0;
        parity_bad   = ^codeword;
        for (int unsigned p = 1; p < CW_WIDTH; p++) begin
            if (codeword[IDX_W'(p)]) syndrome = syndrome ^ SYN_WIDTH'(p);
        end
        for (int unsigned p = 1; p < CW_WIDTH; p++) begin
            if (syndrome == SYN_WIDTH'(p)) flip[IDX_W'(p)] = 1'b1;
        end
        // A syndrome past the last position can only come from a multi-bit error
        if (syndrome == '0) begin
            single_err_c = parity_bad;
        end else if (!parity_bad || 32'(syndrome) >= CW_WIDTH) begin
            double_err_c = 1'b1;
        end else begin
            fixed        = codeword ^ flip;
            single_err_c = 1'b1;
        end
        for (int unsigned k = 0; k < DATA_WIDTH; k++) begin
            data_c[DIDX_W'(k)] = fixed[IDX_W'(data_pos(k))];
        end
    end

endmodule

// File: rtl/secded_stream_channel.sv
// Two-stage SECDED encode/decode stream channel with saturating error counters.
// Optional SECDED_ERR_INJECT_EN adds inj_mask, XORed into the captured stage-1 codeword.
module secded_stream_channel
    import secded_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ECC_WIDTH  = 5,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           in_data,
`ifdef SECDED_ERR_INJECT_EN
    input  logic [DATA_WIDTH+ECC_WIDTH-1:0] inj_mask,
`endif
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_single_err,
    output logic                            out_double_err,
    input  logic                            clear_counts,
    output logic [CNT_WIDTH-1:0]            single_err_count,
    output logic [CNT_WIDTH-1:0]            double_err_count
);

    localparam int unsigned CW_WIDTH  = cw_width(DATA_WIDTH, ECC_WIDTH);
    localparam int unsigned SYN_WIDTH = syn_width(ECC_WIDTH);
    localparam int unsigned IDX_W     = $clog2(CW_WIDTH);
    localparam int unsigned DIDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    if (ECC_WIDTH != ecc_width(DATA_WIDTH)) begin : g_bad_ecc_width
        $error("ECC_WIDTH does not match DATA_WIDTH");
    end

    logic                  s1_valid;
    logic [CW_WIDTH-1:0]   s1_cw;
    logic                  s1_ready;
    logic                  s2_ready;
    logic                  out_xfer;
    logic [CW_WIDTH-1:0]   enc_cw;
    logic [SYN_WIDTH-1:0]  enc_syn;
    logic [CW_WIDTH-1:0]   cw_in;
    logic [DATA_WIDTH-1:0] dec_data;
    logic                  dec_single;
    logic                  dec_double;

    assign s2_ready = !out_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready;
    assign out_xfer = out_valid && out_ready;

    // Encoder: scatter data, derive check bits from the data-only syndrome, then overall parity
    always_comb begin
        enc_cw  = '0;
        enc_syn = '0;
        for (int unsigned k = 0; k < DATA_WIDTH; k++) begin
            enc_cw[IDX_W'(data_pos(k))] = in_data[DIDX_W'(k)];
        end
        for (int unsigned p = 1; p < CW_WIDTH; p++) begin
            if (enc_cw[IDX_W'(p)]) enc_syn = enc_syn ^ SYN_WIDTH'(p);
        end
        for (int unsigned i = 0; i < SYN_WIDTH; i++) begin
            enc_cw[IDX_W'(32'd1 << i)] = ^(enc_syn & SYN_WIDTH'(32'd1 << i));
        end
        enc_cw[0] = ^enc_cw;
    end

`ifdef SECDED_ERR_INJECT_EN
    assign cw_in = enc_cw ^ inj_mask;
`else
    assign cw_in = enc_cw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_cw    <= '0;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid) s1_cw <= cw_in;
        end
    end

    secded_decoder #(
        .DATA_WIDTH(DATA_WIDTH),
        .ECC_WIDTH (ECC_WIDTH)
    ) u_decoder (
        .codeword    (s1_cw),
        .data_c      (dec_data),
        .single_err_c(dec_single),
        .double_err_c(dec_double)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_single_err <= 1'b0;
            out_double_err <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data       <= dec_data;
                out_single_err <= dec_single;
                out_double_err <= dec_double;
            end
        end
    end

    // Counters advance only on an accepted output; clear beats a coincident count
    always_ff @(posedge clk) begin
        if (rst || clear_counts) begin
            single_err_count <= '0;
            double_err_count <= '0;
        end else if (out_xfer) begin
            if (out_single_err && single_err_count != '1)
                single_err_count <= single_err_count + CNT_WIDTH'(1);
            if (out_double_err && double_err_count != '1)
                double_err_count <= double_err_count + CNT_WIDTH'(1);
        end
    end

endmodule
